// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the car-park barrier controller: lane state encodings
// and default debounce/timeout constants.
package parking_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        LANE_IDLE    = 2'd0,
        LANE_OPEN    = 2'd1,
        LANE_PASSING = 2'd2
    } lane_state_e;

    localparam int unsigned DEBOUNCE_DEF = 32'd4;
    localparam int unsigned TIMEOUT_DEF  = 32'd64;

endpackage

// File: rtl/parking_gate_ctrl_gate_lane_fsm.sv
// One barrier lane: debounces request and sensor, runs IDLE/OPEN/PASSING and
// emits a single-cycle completion pulse when a vehicle has cleared the gate.
module gate_lane_fsm
    import parking_gate_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic sens_i,
    input  logic block_i,
    output logic gate_o,
    output logic pulse_o,
    output logic deny_o
);

    localparam int unsigned DCW = $clog2(DEBOUNCE + 32'd1);
    localparam int unsigned TW  = $clog2(TIMEOUT);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE - 32'd1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 32'd1);

    logic [1:0]     raw_s;
    logic [1:0]     filt_q;
    logic [DCW-1:0] cnt_q [2];
    logic           req_f_s;
    logic           sens_f_s;
    logic           req_rise_s;
    logic           req_prev_q;
    lane_state_e    state_q;
    logic [TW-1:0]  timer_q;
    logic           gate_q;
    logic           pulse_q;
    logic           deny_q;

    assign raw_s      = {sens_i, req_i};
    assign req_f_s    = filt_q[0];
    assign sens_f_s   = filt_q[1];
    assign req_rise_s = req_f_s & ~req_prev_q;

    // Debouncers: index 0 = request, 1 = sensor; count never exceeds DEB_LAST.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_q   <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw_s[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    filt_q[i] <= raw_s[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    // Lane FSM with registered gate, pulse and deny outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= LANE_IDLE;
            timer_q    <= '0;
            gate_q     <= 1'b0;
            pulse_q    <= 1'b0;
            deny_q     <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_f_s;
            pulse_q    <= 1'b0;
            deny_q     <= 1'b0;
            case (state_q)
                LANE_IDLE: begin
                    timer_q <= '0;
                    gate_q  <= 1'b0;
                    // block is only consulted here; a later change cannot abort a passage
                    if (req_rise_s && !block_i) begin
                        state_q <= LANE_OPEN;
                        gate_q  <= 1'b1;
                    end else begin
                        deny_q <= req_f_s & block_i;
                    end
                end
                LANE_OPEN: begin
                    if (sens_f_s) begin
                        state_q <= LANE_PASSING;
                    end else if (timer_q == TMO_LAST) begin
                        state_q <= LANE_IDLE;
                        gate_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                LANE_PASSING: begin
                    if (!sens_f_s) begin
                        state_q <= LANE_IDLE;
                        gate_q  <= 1'b0;
                        pulse_q <= 1'b1;
                    end else begin
                        gate_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= LANE_IDLE;
                    gate_q  <= 1'b0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign gate_o  = gate_q;
    assign pulse_o = pulse_q;
    assign deny_o  = deny_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park barrier controller top: entry and exit lanes feeding the occupancy
// counter, plus the sticky error raised by an exit from an empty lot.
module parking_gate_ctrl
    import parking_gate_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_req,
    input  logic in_sens,
    input  logic out_req,
    input  logic out_sens,
    input  logic ff,
    input  logic ef,
    output logic pci,
    output logic pco,
    output logic in_gate,
    output logic out_gate,
    output logic in_deny,
    output logic err
);

    logic pco_s;
    logic exit_deny_unused_s;
    logic err_q;

    gate_lane_fsm #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_entry (
        .clk_i   (clk),
        .rst_ni  (rst),
        .req_i   (in_req),
        .sens_i  (in_sens),
        .block_i (ff),
        .gate_o  (in_gate),
        .pulse_o (pci),
        .deny_o  (in_deny)
    );

    gate_lane_fsm #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_exit (
        .clk_i   (clk),
        .rst_ni  (rst),
        .req_i   (out_req),
        .sens_i  (out_sens),
        .block_i (1'b0),
        .gate_o  (out_gate),
        .pulse_o (pco_s),
        .deny_o  (exit_deny_unused_s)
    );

    // Sticky error: an exit completed while the counter already reads empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (pco_s && ef) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign pco = pco_s;
    assign err = err_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: entry, full lot, timeout, sensor bounce,
// simultaneous completion, exit-from-empty error and reset mid-passage.
module tb_parking_gate_ctrl;

    logic clk = 1'b0;
    logic rst, in_req, in_sens, out_req, out_sens, ff, ef;
    logic pci, pco, in_gate, out_gate, in_deny, err;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    parking_gate_ctrl dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_sens(in_sens),
        .out_req(out_req), .out_sens(out_sens), .ff(ff), .ef(ef),
        .pci(pci), .pco(pco), .in_gate(in_gate), .out_gate(out_gate),
        .in_deny(in_deny), .err(err)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; outputs are read 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_req = 1'b0; in_sens = 1'b0; out_req = 1'b0;
        out_sens = 1'b0; ff = 1'b0; ef = 1'b0;
        step(3);
        chk_cnt++;
        if ({pci, pco, in_gate, out_gate, in_deny, err} !== 6'b000000)
            $display("FAIL reset_outputs: got %b expected 000000", {pci, pco, in_gate, out_gate, in_deny, err});
        else pass_cnt++;
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_entry();
        in_req = 1'b1;
        step(4);
        chk_cnt++;
        if (in_gate !== 1'b0) $display("FAIL entry_early_open: in_gate=%b expected 0", in_gate);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if (in_gate !== 1'b1) $display("FAIL entry_open: in_gate=%b expected 1", in_gate);
        else pass_cnt++;
        step(5);
        in_req = 1'b0;
        in_sens = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk_cnt++;
            if ({in_gate, pci} !== 2'b10) $display("FAIL entry_hold k=%0d: gate,pci=%b expected 10", k, {in_gate, pci});
            else pass_cnt++;
        end
        in_sens = 1'b0;
        step(4);
        chk_cnt++;
        if ({in_gate, pci} !== 2'b10) $display("FAIL entry_prepulse: gate,pci=%b expected 10", {in_gate, pci});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({in_gate, pci, pco} !== 3'b010) $display("FAIL entry_pulse: gate,pci,pco=%b expected 010", {in_gate, pci, pco});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({in_gate, pci} !== 2'b00) $display("FAIL entry_postpulse: gate,pci=%b expected 00", {in_gate, pci});
        else pass_cnt++;
        step(8);
    endtask

    task automatic test_full();
        logic exp_deny;
        ff = 1'b1;
        in_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_deny = (k >= 5) ? 1'b1 : 1'b0;
            chk_cnt++;
            if ({in_gate, pci, in_deny} !== {2'b00, exp_deny})
                $display("FAIL full_lot k=%0d: gate,pci,deny=%b expected %b", k, {in_gate, pci, in_deny}, {2'b00, exp_deny});
            else pass_cnt++;
        end
        in_req = 1'b0;
        ff = 1'b0;
        step(6);
        chk_cnt++;
        if ({in_gate, in_deny} !== 2'b00) $display("FAIL full_release: gate,deny=%b expected 00", {in_gate, in_deny});
        else pass_cnt++;
        step(4);
    endtask

    task automatic test_timeout();
        in_req = 1'b1;
        step(5);
        in_req = 1'b0;
        chk_cnt++;
        if (in_gate !== 1'b1) $display("FAIL timeout_open: in_gate=%b expected 1", in_gate);
        else pass_cnt++;
        step(63);
        chk_cnt++;
        if ({in_gate, pci} !== 2'b10) $display("FAIL timeout_before: gate,pci=%b expected 10", {in_gate, pci});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({in_gate, pci} !== 2'b00) $display("FAIL timeout_close: gate,pci=%b expected 00", {in_gate, pci});
        else pass_cnt++;
        step(8);
    endtask

    task automatic test_bounce();
        in_req = 1'b1;
        step(5);
        in_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_sens = (((k >> 1) & 1) == 0) ? 1'b1 : 1'b0;
            step(1);
            chk_cnt++;
            if ({in_gate, pci} !== 2'b10) $display("FAIL bounce k=%0d: gate,pci=%b expected 10", k, {in_gate, pci});
            else pass_cnt++;
        end
        in_sens = 1'b0;
        // Still in OPEN, so the gate must close on the unchanged 64-cycle timeout.
        step(43);
        chk_cnt++;
        if ({in_gate, pci} !== 2'b10) $display("FAIL bounce_still_open: gate,pci=%b expected 10", {in_gate, pci});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({in_gate, pci} !== 2'b00) $display("FAIL bounce_timeout: gate,pci=%b expected 00", {in_gate, pci});
        else pass_cnt++;
        step(8);
    endtask

    task automatic test_simultaneous();
        in_req = 1'b1; out_req = 1'b1;
        step(5);
        in_req = 1'b0; out_req = 1'b0;
        chk_cnt++;
        if ({in_gate, out_gate} !== 2'b11) $display("FAIL sim_open: gates=%b expected 11", {in_gate, out_gate});
        else pass_cnt++;
        in_sens = 1'b1; out_sens = 1'b1;
        step(8);
        in_sens = 1'b0; out_sens = 1'b0;
        step(4);
        chk_cnt++;
        if ({pci, pco} !== 2'b00) $display("FAIL sim_prepulse: pci,pco=%b expected 00", {pci, pco});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({pci, pco, in_gate, out_gate} !== 4'b1100) $display("FAIL sim_pulse: pci,pco,gates=%b expected 1100", {pci, pco, in_gate, out_gate});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({pci, pco, err} !== 3'b000) $display("FAIL sim_after: pci,pco,err=%b expected 000", {pci, pco, err});
        else pass_cnt++;
        step(8);
    endtask

    task automatic test_err_reset();
        ef = 1'b1;
        out_req = 1'b1;
        step(5);
        out_req = 1'b0;
        out_sens = 1'b1;
        step(8);
        out_sens = 1'b0;
        step(5);
        chk_cnt++;
        if ({pco, out_gate, err} !== 3'b100) $display("FAIL err_pulse: pco,gate,err=%b expected 100", {pco, out_gate, err});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({pco, err} !== 2'b01) $display("FAIL err_set: pco,err=%b expected 01", {pco, err});
        else pass_cnt++;
        ef = 1'b0;
        step(10);
        chk_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky: err=%b expected 1", err);
        else pass_cnt++;
        in_req = 1'b1;
        step(5);
        in_req = 1'b0;
        in_sens = 1'b1;
        step(8);
        chk_cnt++;
        if (in_gate !== 1'b1) $display("FAIL rst_passing_open: in_gate=%b expected 1", in_gate);
        else pass_cnt++;
        rst = 1'b0;
        step(1);
        chk_cnt++;
        if ({pci, pco, in_gate, out_gate, in_deny, err} !== 6'b000000)
            $display("FAIL rst_mid_passage: outs=%b expected 000000", {pci, pco, in_gate, out_gate, in_deny, err});
        else pass_cnt++;
        rst = 1'b1;
        in_sens = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk_cnt++;
            if ({pci, in_gate} !== 2'b00) $display("FAIL rst_no_pulse k=%0d: pci,gate=%b expected 00", k, {pci, in_gate});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_full();
        test_timeout();
        test_bounce();
        test_simultaneous();
        test_err_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
